// File: rtl/l4_route_ctrl_if.sv
// Request/result handshake and column-array command bus of the L4 route sequencer.
// The master modport is the sequencer side; the slave modport is its environment.
interface l4_route_ctrl_if #(
  parameter int NROWS = 32,
  parameter int NCOLS = 32,
  parameter int AW    = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    src_row;
  logic [AW-1:0]    src_col;
  logic [AW-1:0]    tgt_row;
  logic [AW-1:0]    tgt_col;
  logic             done_valid;
  logic             done_ready;
  logic             done_ok;
  logic [7:0]       done_len;
  logic [1:0]       cell_cmd;
  logic [NROWS-1:0] rsel_v;
  logic [NCOLS-1:0] csel_v;
  logic             mark_tgt;
  logic             etch_enb;
  logic [3:0]       status_all;

  modport master (
    input  req_valid, src_row, src_col, tgt_row, tgt_col, done_ready, status_all,
    output req_ready, done_valid, done_ok, done_len, cell_cmd, rsel_v, csel_v,
           mark_tgt, etch_enb
  );

  modport slave (
    output req_valid, src_row, src_col, tgt_row, tgt_col, done_ready, status_all,
    input  req_ready, done_valid, done_ok, done_len, cell_cmd, rsel_v, csel_v,
           mark_tgt, etch_enb
  );
endinterface

// File: rtl/l4_route_ctrl.sv
// Route sequencer for the 4-layer maze-routing array: clear, mark, expand, trace back.
// Define L4_TRACE_EN to include the traceback phase (TR_STEP/TR_CHK).
module l4_route_ctrl #(
  parameter int NROWS   = 32,
  parameter int NCOLS   = 32,
  parameter int AW      = 5,
  parameter int MAX_LEN = 255
) (
  input  logic           clk,
  input  logic           reset,
  l4_route_ctrl_if.master bus
);

  localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
  localparam logic [NROWS-1:0] ROW_ONE = {{(NROWS-1){1'b0}}, 1'b1};
  localparam logic [NCOLS-1:0] COL_ONE = {{(NCOLS-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_MARK_S   = 4'd2,
    S_MARK_T   = 4'd3,
    S_EXP_STEP = 4'd4,
    S_EXP_CHK  = 4'd5,
`ifdef L4_TRACE_EN
    S_TR_STEP  = 4'd6,
    S_TR_CHK   = 4'd7,
`endif
    S_DONE     = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_row_q, src_row_d, src_col_q, src_col_d;
  logic [AW-1:0]    tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
  logic [7:0]       len_q, len_d;
  logic             ok_q, ok_d;
`ifdef L4_TRACE_EN
  logic [7:0]       trc_q, trc_d;
`endif

  logic             req_ready_q, req_ready_d;
  logic             done_valid_q, done_valid_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [NROWS-1:0] rsel_q, rsel_d;
  logic [NCOLS-1:0] csel_q, csel_d;
  logic             mark_tgt_q, mark_tgt_d;
  logic             etch_enb_q, etch_enb_d;

`ifdef L4_TRACE_EN
  logic [1:0] unused_status;
  assign unused_status = bus.status_all[3:2];
`else
  logic [2:0] unused_status;
  assign unused_status = bus.status_all[3:1];
`endif

  // State, request context and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_row_q    <= '0;
      src_col_q    <= '0;
      tgt_row_q    <= '0;
      tgt_col_q    <= '0;
      len_q        <= 8'd0;
      ok_q         <= 1'b0;
`ifdef L4_TRACE_EN
      trc_q        <= 8'd0;
`endif
      req_ready_q  <= 1'b1;
      done_valid_q <= 1'b0;
      cmd_q        <= 2'b00;
      rsel_q       <= '0;
      csel_q       <= '0;
      mark_tgt_q   <= 1'b0;
      etch_enb_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_row_q    <= src_row_d;
      src_col_q    <= src_col_d;
      tgt_row_q    <= tgt_row_d;
      tgt_col_q    <= tgt_col_d;
      len_q        <= len_d;
      ok_q         <= ok_d;
`ifdef L4_TRACE_EN
      trc_q        <= trc_d;
`endif
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
      cmd_q        <= cmd_d;
      rsel_q       <= rsel_d;
      csel_q       <= csel_d;
      mark_tgt_q   <= mark_tgt_d;
      etch_enb_q   <= etch_enb_d;
    end
  end

  // Next-state and context update; status_all is only looked at in the CHK states.
  always_comb begin
    state_d   = state_q;
    src_row_d = src_row_q;
    src_col_d = src_col_q;
    tgt_row_d = tgt_row_q;
    tgt_col_d = tgt_col_q;
    len_d     = len_q;
    ok_d      = ok_q;
`ifdef L4_TRACE_EN
    trc_d     = trc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          src_row_d = bus.src_row;
          src_col_d = bus.src_col;
          tgt_row_d = bus.tgt_row;
          tgt_col_d = bus.tgt_col;
          len_d     = 8'd0;
          ok_d      = 1'b0;
`ifdef L4_TRACE_EN
          trc_d     = 8'd0;
`endif
          if ((bus.src_row == bus.tgt_row) && (bus.src_col == bus.tgt_col)) begin
            state_d = S_DONE;
            ok_d    = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR:  state_d = S_MARK_S;
      S_MARK_S: state_d = S_MARK_T;
      S_MARK_T: state_d = S_EXP_STEP;
      S_EXP_STEP: begin
        state_d = S_EXP_CHK;
        if (len_q != MAX_LEN_C) begin
          len_d = len_q + 8'd1;
        end else begin
          len_d = len_q;
        end
      end
      S_EXP_CHK: begin
        if (!bus.status_all[0]) begin
`ifdef L4_TRACE_EN
          state_d = S_TR_STEP;
`else
          state_d = S_DONE;
          ok_d    = 1'b1;
`endif
        end else if (len_q == MAX_LEN_C) begin
          state_d = S_DONE;
          ok_d    = 1'b0;
        end else begin
          state_d = S_EXP_STEP;
        end
      end
`ifdef L4_TRACE_EN
      S_TR_STEP: begin
        state_d = S_TR_CHK;
        trc_d   = trc_q + 8'd1;
      end
      S_TR_CHK: begin
        // A trace that runs as long as the expansion without reaching the source is broken.
        if (!bus.status_all[1]) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end else if (trc_q == len_q) begin
          state_d = S_DONE;
          ok_d    = 1'b0;
        end else begin
          state_d = S_TR_STEP;
        end
      end
`endif
      S_DONE: begin
        if (bus.done_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered command lines up with the state.
  always_comb begin
    req_ready_d  = 1'b0;
    done_valid_d = 1'b0;
    cmd_d        = 2'b00;
    rsel_d       = '0;
    csel_d       = '0;
    mark_tgt_d   = 1'b0;
    etch_enb_d   = 1'b0;
    case (state_d)
      S_IDLE: req_ready_d = 1'b1;
      S_CLEAR: begin
        cmd_d  = 2'b01;
        rsel_d = '1;
        csel_d = '1;
      end
      S_MARK_S: begin
        cmd_d  = 2'b10;
        rsel_d = ROW_ONE << src_row_d;
        csel_d = COL_ONE << src_col_d;
      end
      S_MARK_T: begin
        cmd_d      = 2'b10;
        mark_tgt_d = 1'b1;
        rsel_d     = ROW_ONE << tgt_row_d;
        csel_d     = COL_ONE << tgt_col_d;
      end
      S_EXP_STEP: begin
        cmd_d  = 2'b11;
        rsel_d = '1;
        csel_d = '1;
      end
`ifdef L4_TRACE_EN
      S_TR_STEP: begin
        cmd_d      = 2'b11;
        etch_enb_d = 1'b1;
        rsel_d     = '1;
        csel_d     = '1;
      end
`endif
      S_DONE: done_valid_d = 1'b1;
      default: req_ready_d = 1'b0;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_ok    = ok_q;
  assign bus.done_len   = len_q;
  assign bus.cell_cmd   = cmd_q;
  assign bus.rsel_v     = rsel_q;
  assign bus.csel_v     = csel_q;
  assign bus.mark_tgt   = mark_tgt_q;
  assign bus.etch_enb   = etch_enb_q;

endmodule

// File: tb/tb_l4_route_ctrl.sv
// Directed bench for l4_route_ctrl with a behavioural column-array status model.
// Expectations follow L4_TRACE_EN the same way the design does.
module tb_l4_route_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   reach_need;
  int   trace_need;
  int   exp_cnt;
  int   tr_cnt;

  logic [1:0]  cmd_h  [0:31];
  logic [31:0] rsel_h [0:31];
  logic [31:0] csel_h [0:31];
  logic        mark_h [0:31];

  int done_cyc, n_exp, n_tr, n_cmd;

`ifdef L4_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  l4_route_ctrl_if #(.NROWS(32), .NCOLS(32), .AW(5)) bus ();

  l4_route_ctrl #(.NROWS(32), .NCOLS(32), .AW(5), .MAX_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: counts expansion/trace steps since the last CLEAR.
  always @(posedge clk) begin
    if (bus.cell_cmd == 2'b01) begin
      exp_cnt <= 0;
      tr_cnt  <= 0;
    end else if (bus.cell_cmd == 2'b11 && !bus.etch_enb) begin
      exp_cnt <= exp_cnt + 1;
    end else if (bus.cell_cmd == 2'b11 && bus.etch_enb) begin
      tr_cnt <= tr_cnt + 1;
    end
  end

  assign bus.status_all = {2'b11, (tr_cnt >= trace_need) ? 1'b0 : 1'b1,
                                  (exp_cnt >= reach_need) ? 1'b0 : 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [4:0] sr, input logic [4:0] sc,
                           input logic [4:0] tr, input logic [4:0] tc);
    bus.src_row   = sr;
    bus.src_col   = sc;
    bus.tgt_row   = tr;
    bus.tgt_col   = tc;
    bus.req_valid = 1'b1;
  endtask

  task automatic run_to_done(input int budget, output int dc, output int ne,
                             output int nt, output int nc);
    dc = -1; ne = 0; nt = 0; nc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (c < 32) begin
        cmd_h[c]  = bus.cell_cmd;
        rsel_h[c] = bus.rsel_v;
        csel_h[c] = bus.csel_v;
        mark_h[c] = bus.mark_tgt;
      end
      if (bus.cell_cmd != 2'b00) nc++;
      if (bus.cell_cmd == 2'b11 && !bus.etch_enb) ne++;
      if (bus.cell_cmd == 2'b11 && bus.etch_enb) nt++;
      if (bus.done_valid) begin
        dc = c;
        break;
      end
    end
  endtask

  task automatic release_done();
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_valid", 32'(bus.done_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
    chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'd0);
    chk({tag, "_done_ok"},    32'(bus.done_ok), 32'd0);
    chk({tag, "_done_len"},   32'(bus.done_len), 32'd0);
    chk({tag, "_cmd"},        32'(bus.cell_cmd), 32'd0);
    chk({tag, "_rsel"},       bus.rsel_v, 32'd0);
    chk({tag, "_csel"},       bus.csel_v, 32'd0);
    chk({tag, "_marks"},      {30'd0, bus.mark_tgt, bus.etch_enb}, 32'd0);
  endtask

  initial begin
    bit stable;
    checks = 0; errors = 0;
    reach_need = 1000; trace_need = 1000;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.done_ready = 1'b0;
    bus.src_row = 5'd0; bus.src_col = 5'd0; bus.tgt_row = 5'd0; bus.tgt_col = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Distance-3 route (0,0) -> (0,3)
    reach_need = 3; trace_need = 3;
    start_req(5'd0, 5'd0, 5'd0, 5'd3);
    run_to_done(60, done_cyc, n_exp, n_tr, n_cmd);
    chk("r1_clear_cmd",  32'(cmd_h[1]), 32'd1);
    chk("r1_clear_rsel", rsel_h[1], 32'hFFFF_FFFF);
    chk("r1_clear_csel", csel_h[1], 32'hFFFF_FFFF);
    chk("r1_marks",      {30'd0, cmd_h[2]}, 32'd2);
    chk("r1_marks_sel",  {rsel_h[2][15:0], csel_h[2][15:0]}, 32'h0001_0001);
    chk("r1_marks_tgt",  32'(mark_h[2]), 32'd0);
    chk("r1_markt",      {30'd0, cmd_h[3]}, 32'd2);
    chk("r1_markt_sel",  {rsel_h[3][15:0], csel_h[3][15:0]}, 32'h0001_0008);
    chk("r1_markt_tgt",  32'(mark_h[3]), 32'd1);
    chk("r1_step1",      32'(cmd_h[4]), 32'd3);
    chk("r1_chk1",       32'(cmd_h[5]), 32'd0);
    chk("r1_done_cyc",   32'(done_cyc), TRACE ? 32'd16 : 32'd10);
    chk("r1_ok",         32'(bus.done_ok), 32'd1);
    chk("r1_len",        32'(bus.done_len), 32'd3);
    chk("r1_exp_steps",  32'(n_exp), 32'd3);
    chk("r1_tr_steps",   32'(n_tr), TRACE ? 32'd3 : 32'd0);
    chk("r1_busy_ready", 32'(bus.req_ready), 32'd0);
    release_done();

    // Unreachable target hits the step limit
    reach_need = 1000; trace_need = 1000;
    start_req(5'd1, 5'd2, 5'd20, 5'd30);
    run_to_done(60, done_cyc, n_exp, n_tr, n_cmd);
    chk("r2_done_cyc",  32'(done_cyc), 32'd20);
    chk("r2_ok",        32'(bus.done_ok), 32'd0);
    chk("r2_len",       32'(bus.done_len), 32'd8);
    chk("r2_exp_steps", 32'(n_exp), 32'd8);
    chk("r2_tr_steps",  32'(n_tr), 32'd0);
    release_done();

    // src == tgt completes without commands, then the result is held
    start_req(5'd5, 5'd5, 5'd5, 5'd5);
    run_to_done(10, done_cyc, n_exp, n_tr, n_cmd);
    chk("r3_done_cyc", 32'(done_cyc), 32'd1);
    chk("r3_ok",       32'(bus.done_ok), 32'd1);
    chk("r3_len",      32'(bus.done_len), 32'd0);
    chk("r3_no_cmd",   32'(n_cmd), 32'd0);

    reach_need = 1; trace_need = 1;
    start_req(5'd2, 5'd2, 5'd2, 5'd3);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(bus.done_valid === 1'b1 && bus.done_ok === 1'b1 && bus.done_len === 8'd0 &&
            bus.req_ready === 1'b0 && bus.cell_cmd === 2'b00)) stable = 1'b0;
    end
    chk("r4_hold_stable", 32'(stable), 32'd1);
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    chk("r4_ready_after", 32'(bus.req_ready), 32'd1);
    chk("r4_cmd_after",   32'(bus.cell_cmd), 32'd0);
    run_to_done(60, done_cyc, n_exp, n_tr, n_cmd);
    chk("r4_clear",    32'(cmd_h[1]), 32'd1);
    chk("r4_done_cyc", 32'(done_cyc), TRACE ? 32'd8 : 32'd6);
    chk("r4_ok",       32'(bus.done_ok), 32'd1);
    chk("r4_len",      32'(bus.done_len), 32'd1);
    release_done();

    // Reset during EXP_STEP 2, then a fresh request
    reach_need = 3; trace_need = 3;
    start_req(5'd0, 5'd0, 5'd0, 5'd3);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
    chk("r5_in_step2", 32'(bus.cell_cmd), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("r5_rst");
    reset = 1'b0;
    start_req(5'd3, 5'd4, 5'd3, 5'd7);
    run_to_done(60, done_cyc, n_exp, n_tr, n_cmd);
    chk("r5_clear_cmd",  32'(cmd_h[1]), 32'd1);
    chk("r5_clear_rsel", rsel_h[1], 32'hFFFF_FFFF);
    chk("r5_clear_csel", csel_h[1], 32'hFFFF_FFFF);
    chk("r5_done_cyc",   32'(done_cyc), TRACE ? 32'd16 : 32'd10);
    chk("r5_ok",         32'(bus.done_ok), 32'd1);
    chk("r5_len",        32'(bus.done_len), 32'd3);
    release_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
